layer_compositor: RTL and testbench

//   Pipelined, parametrised sprite compositor for the VGA path. Overlays N_LAYERS

---
 rtl/layer_compositor.sv | 224 ++++++++++++++++++++++
 tb/tb_layer_compositor.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// layer_compositor
//   Five-stage sprite compositor for the VGA path. N_LAYERS rectangular sprites
//   are overlaid on a background palette index with fixed priority (layer 0
//   wins) and colour-key transparency. The winning index is looked up in a
//   writable palette RAM, and the colour is scaled by a frame-stepped fade level.
//   Sprite enables and positions are shadowed on frame_start, so game logic can
//   update them at any time without tearing.
//
// Ports
//   Clk, Reset                 clock, asynchronous active-high reset
//   frame_start                1-cycle pulse per frame (blanking)
//   pix_valid, DrawX, DrawY    pixel coordinate stream
//   layer_en/x/y               per-layer enable and top-left corner (shadowed)
//   rom_addr / rom_data        per-layer sprite ROM port (1-cycle read latency)
//   pal_we/waddr/wdata         palette RAM write port, {R,G,B}
//   fade_req, fade_dark        fade transition request / fully dark flag
//   out_valid, VGA_R/G/B       output pixel; RGB is 0 when out_valid is low
//
// Fade FSM
//   state    | meaning
//   SHOWN    | lvl=16, full brightness, waits for fade_req
//   FADE_OUT | lvl drops by 1 every FADE_DIV frame_starts down to 0
//   DARK     | lvl=0, fade_dark=1, waits for fade_req
//   FADE_IN  | lvl rises by 1 every FADE_DIV frame_starts up to 16

module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int PIX_W    = 4,
  parameter int TRANSP   = 0,
  parameter int BG_IDX   = 1,
  parameter int FADE_DIV = 2,
  localparam int AW      = $clog2(SPR_W * SPR_H)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*10-1:0]    layer_x,
  input  logic [N_LAYERS*10-1:0]    layer_y,
  output logic [N_LAYERS*AW-1:0]    rom_addr,
  input  logic [N_LAYERS*PIX_W-1:0] rom_data,
  input  logic                      pal_we,
  input  logic [PIX_W-1:0]          pal_waddr,
  input  logic [23:0]               pal_wdata,
  input  logic                      fade_req,
  output logic                      fade_dark,
  output logic                      out_valid,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B
);

  localparam logic [PIX_W-1:0] TRANSP_IDX = PIX_W'(TRANSP);
  localparam logic [PIX_W-1:0] BG_SEL     = PIX_W'(BG_IDX);
  localparam int               DW         = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DW-1:0]    DIV_LOAD   = DW'(FADE_DIV - 1);

  typedef enum logic [1:0] {SHOWN, FADE_OUT, DARK, FADE_IN} fade_state_t;

  fade_state_t          state;
  logic [4:0]           lvl;
  logic [DW-1:0]        div_cnt;

  logic [N_LAYERS-1:0]    sh_en;
  logic [N_LAYERS*10-1:0] sh_x;
  logic [N_LAYERS*10-1:0] sh_y;

  logic [N_LAYERS-1:0]    hit_c;
  logic [N_LAYERS*AW-1:0] addr_c;
  logic                   s1_valid, s2_valid, s3_valid, s4_valid;
  logic [N_LAYERS-1:0]    s1_hit, s2_hit;
  logic [PIX_W-1:0]       sel_c, s3_sel;
  logic [23:0]            pal_mem [2**PIX_W];
  logic [23:0]            pal_q;

  // Span test widened to 11 bits so a sprite near column/row 1023 clips
  // instead of wrapping its right/bottom edge back to 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] start,
                                   input int len);
    return ({1'b0, pos} >= {1'b0, start}) &&
           ({1'b0, pos} <  ({1'b0, start} + 11'(len)));
  endfunction

  // (c*lvl)>>4; lvl=16 is an exact pass-through.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] l);
    return 8'(({4'b0, c} * {7'b0, l}) >> 4);
  endfunction

  // Shadow registers: a pixel in the frame_start cycle still sees the old values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_en <= '0;
      sh_x  <= '0;
      sh_y  <= '0;
    end else if (frame_start) begin
      sh_en <= layer_en;
      sh_x  <= layer_x;
      sh_y  <= layer_y;
    end
  end

  always_comb begin
    hit_c  = '0;
    addr_c = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      hit_c[i] = pix_valid && sh_en[i] &&
                 in_span(DrawX, sh_x[i*10 +: 10], SPR_W) &&
                 in_span(DrawY, sh_y[i*10 +: 10], SPR_H);
      if (hit_c[i])
        addr_c[i*AW +: AW] = AW'((int'(DrawY) - int'(sh_y[i*10 +: 10])) * SPR_W +
                                 (int'(DrawX) - int'(sh_x[i*10 +: 10])));
    end
  end

  // Walk from lowest priority up so the lowest opaque layer is written last.
  always_comb begin
    sel_c = BG_SEL;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (s2_hit[i] && (rom_data[i*PIX_W +: PIX_W] != TRANSP_IDX))
        sel_c = rom_data[i*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_hit    <= '0;
      rom_addr  <= '0;
      s2_valid  <= 1'b0;
      s2_hit    <= '0;
      s3_valid  <= 1'b0;
      s3_sel    <= '0;
      s4_valid  <= 1'b0;
      out_valid <= 1'b0;
      VGA_R     <= 8'd0;
      VGA_G     <= 8'd0;
      VGA_B     <= 8'd0;
    end else begin
      s1_valid  <= pix_valid;
      s1_hit    <= hit_c;
      rom_addr  <= addr_c;
      s2_valid  <= s1_valid;
      s2_hit    <= s1_hit;
      s3_valid  <= s2_valid;
      s3_sel    <= sel_c;
      s4_valid  <= s3_valid;
      out_valid <= s4_valid;
      VGA_R     <= s4_valid ? scale(pal_q[23:16], lvl) : 8'd0;
      VGA_G     <= s4_valid ? scale(pal_q[15:8],  lvl) : 8'd0;
      VGA_B     <= s4_valid ? scale(pal_q[7:0],   lvl) : 8'd0;
    end
  end

  // Palette RAM is left unreset; a colliding write/read returns the old entry.
  always_ff @(posedge Clk) begin
    if (pal_we)
      pal_mem[pal_waddr] <= pal_wdata;
    pal_q <= pal_mem[s3_sel];
  end

  // fade_req is taken in any cycle; the level only moves on frame_start, and the
  // divider is reloaded on acceptance so the first step lands on a later frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= SHOWN;
      lvl       <= 5'd16;
      div_cnt   <= '0;
      fade_dark <= 1'b0;
    end else begin
      case (state)
        SHOWN: begin
          if (fade_req) begin
            state   <= FADE_OUT;
            div_cnt <= DIV_LOAD;
          end
        end
        FADE_OUT: begin
          if (frame_start) begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LOAD;
              lvl     <= lvl - 5'd1;
              if (lvl == 5'd1) begin
                state     <= DARK;
                fade_dark <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt - DW'(1);
            end
          end
        end
        DARK: begin
          if (fade_req) begin
            state     <= FADE_IN;
            div_cnt   <= DIV_LOAD;
            fade_dark <= 1'b0;
          end
        end
        FADE_IN: begin
          if (frame_start) begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LOAD;
              lvl     <= lvl + 5'd1;
              if (lvl == 5'd15)
                state <= SHOWN;
            end else begin
              div_cnt <= div_cnt - DW'(1);
            end
          end
        end
        default: begin
          state     <= SHOWN;
          lvl       <= 5'd16;
          fade_dark <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int PW = 4;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_start = 1'b0;
  logic            pix_valid = 1'b0;
  logic [9:0]      DrawX = '0;
  logic [9:0]      DrawY = '0;
  logic [N-1:0]    layer_en = '0;
  logic [N*10-1:0] layer_x = '0;
  logic [N*10-1:0] layer_y = '0;
  logic [N*AW-1:0] rom_addr;
  logic [N*PW-1:0] rom_data;
  logic            pal_we = 1'b0;
  logic [PW-1:0]   pal_waddr = '0;
  logic [23:0]     pal_wdata = '0;
  logic            fade_req = 1'b0;
  logic            fade_dark;
  logic            out_valid;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .layer_en(layer_en), .layer_x(layer_x),
    .layer_y(layer_y), .rom_addr(rom_addr), .rom_data(rom_data), .pal_we(pal_we),
    .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .fade_req(fade_req),
    .fade_dark(fade_dark), .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  // Sprite ROMs: one-cycle read latency.
  logic [3:0] rom_mem [N][1024];
  always @(posedge Clk)
    for (int i = 0; i < N; i++)
      rom_data[i*PW +: PW] <= rom_mem[i][rom_addr[i*AW +: AW]];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [23:0] rgb; int cyc; } exp_t;
  exp_t q[$];
  exp_t e_mon;

  // Reference model state
  logic [N-1:0] m_en = '0;
  int           m_x [N];
  int           m_y [N];
  logic [23:0]  m_pal [16];
  int           m_lvl = 16;

  function automatic logic [7:0] scale8(input logic [7:0] c, input int l);
    return 8'((int'(c) * l) >> 4);
  endfunction

  function automatic logic [23:0] model_pixel(input int x, input int y);
    int sel;
    logic [3:0] d;
    logic [23:0] c;
    sel = 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_en[i] && x >= m_x[i] && x < m_x[i] + 32 && y >= m_y[i] && y < m_y[i] + 32) begin
        d = rom_mem[i][(y - m_y[i]) * 32 + (x - m_x[i])];
        if (d != 4'd0) sel = int'(d);
      end
    end
    c = m_pal[sel];
    return {scale8(c[23:16], m_lvl), scale8(c[15:8], m_lvl), scale8(c[7:0], m_lvl)};
  endfunction

  // Scoreboard consumer: every output pixel must match the queued expectation
  // exactly 5 cycles after its input; blanked cycles must carry RGB=0.
  always @(negedge Clk) begin
    if (!Reset) begin
      checks++;
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel got %h expected no output", {VGA_R, VGA_G, VGA_B});
        end else begin
          e_mon = q.pop_front();
          if ({VGA_R, VGA_G, VGA_B} !== e_mon.rgb || (cyc - e_mon.cyc) != 5) begin
            errors++;
            $display("FAIL pixel got %h after %0d cycles expected %h after 5",
                     {VGA_R, VGA_G, VGA_B}, cyc - e_mon.cyc, e_mon.rgb);
          end
        end
      end else if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
        errors++;
        $display("FAIL blank_rgb got %h expected 000000", {VGA_R, VGA_G, VGA_B});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic latch_model();
    m_en = layer_en;
    for (int i = 0; i < N; i++) begin
      m_x[i] = int'(layer_x[i*10 +: 10]);
      m_y[i] = int'(layer_y[i*10 +: 10]);
    end
  endtask

  task automatic frame_pulse(input logic req);
    frame_start = 1'b1;
    fade_req = req;
    tick(1);
    frame_start = 1'b0;
    fade_req = 1'b0;
    latch_model();
  endtask

  task automatic pal_write(input int a, input logic [23:0] d);
    pal_we = 1'b1;
    pal_waddr = PW'(a);
    pal_wdata = d;
    tick(1);
    pal_we = 1'b0;
    m_pal[a] = d;
  endtask

  task automatic set_layer(input int i, input logic en, input int x, input int y);
    layer_en[i] = en;
    layer_x[i*10 +: 10] = 10'(x);
    layer_y[i*10 +: 10] = 10'(y);
  endtask

  task automatic fill_rom(input int i, input logic [3:0] v);
    for (int a = 0; a < 1024; a++) rom_mem[i][a] = v;
  endtask

  task automatic drive_pixel(input int x, input int y);
    exp_t e;
    pix_valid = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    e.rgb = model_pixel(x, y);
    e.cyc = cyc;
    q.push_back(e);
    tick(1);
  endtask

  task automatic drain();
    int n;
    pix_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin tick(1); n++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
    tick(2);
  endtask

  task automatic check_rom_addr(input string nm, input int i, input int exp);
    checks++;
    if (rom_addr[i*AW +: AW] !== AW'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, rom_addr[i*AW +: AW], exp);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0 || fade_dark !== 1'b0 ||
        rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b rgb=%h dark=%b addr=%h expected 0",
               out_valid, {VGA_R, VGA_G, VGA_B}, fade_dark, rom_addr);
    end
    Reset = 1'b0;
    tick(1);
  endtask

  task automatic test_background();
    pal_write(1, 24'h102030);
    for (int i = 2; i < 16; i++) pal_write(i, {8'(i * 17), 8'(255 - i * 16), 8'(i * 5)});
    pal_write(0, 24'h0C0C0C);
    frame_pulse(1'b0);
    drive_pixel(5, 5);
    drain();
  endtask

  task automatic test_priority();
    fill_rom(0, 4'd0);
    fill_rom(1, 4'd7);
    pal_write(7, 24'hFF0000);
    set_layer(0, 1'b1, 100, 100);
    set_layer(1, 1'b1, 100, 100);
    frame_pulse(1'b0);
    drive_pixel(100, 100);
    drive_pixel(99, 100);
    drive_pixel(131, 131);
    drive_pixel(132, 100);
    drive_pixel(100, 132);
    drain();
    fill_rom(0, 4'd3);
    pal_write(3, 24'h00FF00);
    drive_pixel(100, 100);
    drive_pixel(115, 120);
    drain();
  endtask

  task automatic test_clip();
    set_layer(0, 1'b0, 100, 100);
    set_layer(1, 1'b0, 100, 100);
    set_layer(2, 1'b1, 1000, 200);
    set_layer(3, 1'b1, 0, 0);
    for (int a = 0; a < 1024; a++) rom_mem[2][a] = 4'(a % 15 + 1);
    fill_rom(3, 4'd9);
    frame_pulse(1'b0);
    drive_pixel(1010, 205);
    check_rom_addr("clip_hit_col10", 2, 170);
    check_rom_addr("clip_other_layer", 3, 0);
    drive_pixel(1023, 10);
    check_rom_addr("clip_nowrap_x0", 3, 0);
    check_rom_addr("clip_row_miss", 2, 0);
    drive_pixel(1023, 231);
    check_rom_addr("clip_corner", 2, 1015);
    drive_pixel(5, 10);
    check_rom_addr("clip_layer3", 3, 325);
    drive_pixel(1005, 232);
    check_rom_addr("clip_below", 2, 0);
    drain();
  endtask

  task automatic test_frame_latch();
    set_layer(2, 1'b0, 0, 0);
    set_layer(3, 1'b0, 0, 0);
    set_layer(0, 1'b0, 100, 100);
    set_layer(1, 1'b1, 100, 100);
    frame_pulse(1'b0);
    drive_pixel(100, 100);
    set_layer(1, 1'b1, 300, 100);
    drive_pixel(100, 100);
    drive_pixel(300, 100);
    frame_start = 1'b1;
    drive_pixel(100, 100);
    frame_start = 1'b0;
    latch_model();
    drive_pixel(300, 100);
    drive_pixel(100, 100);
    drain();
  endtask

  task automatic test_fade();
    for (int i = 0; i < N; i++) set_layer(i, 1'b0, 0, 0);
    frame_pulse(1'b0);
    pal_write(1, 24'hFF80FF);
    frame_pulse(1'b1);
    for (int k = 1; k <= 32; k++) begin
      frame_pulse(1'b0);
      if (k == 5) begin fade_req = 1'b1; tick(1); fade_req = 1'b0; end
      m_lvl = 16 - k / 2;
      checks++;
      if (fade_dark !== (k == 32)) begin
        errors++;
        $display("FAIL fade_out_dark k=%0d got %b expected %b", k, fade_dark, k == 32);
      end
      if (k == 16 || k == 32) begin drive_pixel(3, 3); drain(); end
    end
    frame_pulse(1'b1);
    for (int k = 1; k <= 32; k++) begin
      frame_pulse(1'b0);
      if (k == 3) begin fade_req = 1'b1; tick(1); fade_req = 1'b0; end
      m_lvl = k / 2;
      checks++;
      if (fade_dark !== 1'b0) begin
        errors++;
        $display("FAIL fade_in_dark k=%0d got %b expected 0", k, fade_dark);
      end
      if (k == 8 || k == 32) begin drive_pixel(3, 3); drain(); end
    end
  endtask

  task automatic test_reset_mid();
    set_layer(1, 1'b1, 100, 100);
    frame_pulse(1'b0);
    frame_pulse(1'b1);
    frame_pulse(1'b0);
    frame_pulse(1'b0);
    m_lvl = 15;
    for (int i = 0; i < 7; i++) drive_pixel(100 + i, 100);
    Reset = 1'b1;
    pix_valid = 1'b0;
    q.delete();
    m_en = '0;
    m_lvl = 16;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0 || fade_dark !== 1'b0 ||
        rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid got v=%b rgb=%h dark=%b addr=%h expected 0",
               out_valid, {VGA_R, VGA_G, VGA_B}, fade_dark, rom_addr);
    end
    tick(2);
    Reset = 1'b0;
    tick(1);
    drive_pixel(100, 100);
    drain();
    frame_pulse(1'b0);
    frame_pulse(1'b0);
    frame_pulse(1'b0);
    drive_pixel(100, 100);
    drive_pixel(131, 131);
    drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      fill_rom(i, 4'd0);
      m_x[i] = 0;
      m_y[i] = 0;
    end
    for (int i = 0; i < 16; i++) m_pal[i] = 24'h0;
    test_reset();
    test_background();
    test_priority();
    test_clip();
    test_frame_latch();
    test_fade();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
